// File: rtl/ls30rot_tracker_if.sv
// Bus bundle for the LS-30 rotary tracker: sampling/control inputs from the
// game logic and the per-channel position/step/direction outputs.
interface ls30rot_tracker_if #(
  parameter int NUM_CH = 2,
  parameter int PHASES = 4
);
  logic                       sample_en;
  logic                       wait_data;
  logic [NUM_CH-1:0]          recenter;
  logic [NUM_CH*PHASES-1:0]   rot_n;
  logic [NUM_CH*4-1:0]        pos;
  logic [NUM_CH-1:0]          step;
  logic [NUM_CH-1:0]          dir_ccw;

  modport master (
    output sample_en, wait_data, recenter, rot_n,
    input  pos, step, dir_ccw
  );

  modport slave (
    input  sample_en, wait_data, recenter, rot_n,
    output pos, step, dir_ccw
  );
endinterface

// File: rtl/ls30rot_tracker.sv
// Multi-channel rotary-joystick tracker. Each channel synchronises its raw
// active-low switch groups, debounces them on the sample strobe, turns
// transitions between adjacent one-hot phase codes into +/-1 steps and keeps
// an absolute position modulo POSITIONS.
module ls30rot_tracker #(
  parameter int NUM_CH    = 2,
  parameter int PHASES    = 4,
  parameter int POSITIONS = 12,
  parameter int DEBOUNCE  = 3,
  parameter int RESET_POS = 11
) (
  input logic            clk,
  input logic            rst_n,
  ls30rot_tracker_if.slave bus
);

  localparam int              CNT_W     = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] DB_C     = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [3:0]      POS_MAX   = 4'(POSITIONS - 1);
  localparam logic [3:0]      POS_RST   = 4'(RESET_POS);

  // Input synchroniser (positive logic after inversion)
  logic [NUM_CH-1:0][PHASES-1:0] sync1_d, sync1_q;
  logic [NUM_CH-1:0][PHASES-1:0] sync2_d, sync2_q;
  // Debounce state
  logic [NUM_CH-1:0][PHASES-1:0] cand_d, cand_q;
  logic [NUM_CH-1:0][PHASES-1:0] stable_d, stable_q;
  logic [NUM_CH-1:0][CNT_W-1:0]  cnt_d, cnt_q;
  // One-hot history
  logic [NUM_CH-1:0][PHASES-1:0] hist_d, hist_q;
  logic [NUM_CH-1:0]             hist_vld_d, hist_vld_q;
  // Step waiting to be applied on the cycle after accept
  logic [NUM_CH-1:0]             pend_vld_d, pend_vld_q;
  logic [NUM_CH-1:0]             pend_ccw_d, pend_ccw_q;
  // Registered outputs
  logic [NUM_CH-1:0][3:0]        pos_d, pos_q;
  logic [NUM_CH-1:0]             step_d, step_q;
  logic [NUM_CH-1:0]             dir_d, dir_q;

  // Per-channel combinational helpers
  logic [NUM_CH-1:0]             accept;
  logic [NUM_CH-1:0][PHASES-1:0] rot_l;
  logic [NUM_CH-1:0][PHASES-1:0] rot_r;

  assign sync1_d = ~bus.rot_n;
  assign sync2_d = sync1_q;

  // Debounce, classify accepted codes and apply pending steps to the position
  always_comb begin
    cand_d     = cand_q;
    stable_d   = stable_q;
    cnt_d      = cnt_q;
    hist_d     = hist_q;
    hist_vld_d = hist_vld_q;
    pend_vld_d = '0;
    pend_ccw_d = '0;
    pos_d      = pos_q;
    step_d     = '0;
    dir_d      = dir_q;
    accept     = '0;
    rot_l      = '0;
    rot_r      = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      rot_l[c] = {hist_q[c][PHASES-2:0], hist_q[c][PHASES-1]};
      rot_r[c] = {hist_q[c][0], hist_q[c][PHASES-1:1]};

      // Debounce: count consecutive identical samples of the synced code
      if (bus.sample_en) begin
        if (sync2_q[c] == cand_q[c]) begin
          if (cnt_q[c] != DB_C) begin
            cnt_d[c] = cnt_q[c] + CNT_ONE;
          end else begin
            cnt_d[c] = cnt_q[c];
          end
        end else begin
          cand_d[c] = sync2_q[c];
          cnt_d[c]  = CNT_ONE;
        end
        accept[c] = (cnt_d[c] == DB_C) && (cand_d[c] != stable_q[c]);
      end else begin
        accept[c] = 1'b0;
      end

      // Classification: only one-hot codes touch the history
      if (accept[c]) begin
        stable_d[c] = cand_d[c];
        if ($onehot(cand_d[c])) begin
          hist_d[c]     = cand_d[c];
          hist_vld_d[c] = 1'b1;
          if (hist_vld_q[c] && (cand_d[c] == rot_l[c])) begin
            pend_vld_d[c] = 1'b1;
            pend_ccw_d[c] = 1'b0;
          end else if (hist_vld_q[c] && (cand_d[c] == rot_r[c])) begin
            pend_vld_d[c] = 1'b1;
            pend_ccw_d[c] = 1'b1;
          end else begin
            pend_vld_d[c] = 1'b0;
            pend_ccw_d[c] = 1'b0;
          end
        end else begin
          hist_d[c] = hist_q[c];
        end
      end else begin
        stable_d[c] = stable_q[c];
      end

      // Recenter wins over any step and drops the history and pending step
      if (bus.recenter[c]) begin
        pos_d[c]      = POS_RST;
        step_d[c]     = 1'b0;
        hist_vld_d[c] = 1'b0;
        pend_vld_d[c] = 1'b0;
        pend_ccw_d[c] = 1'b0;
      end else if (pend_vld_q[c] && !bus.wait_data) begin
        step_d[c] = 1'b1;
        dir_d[c]  = pend_ccw_q[c];
        if (pend_ccw_q[c]) begin
          pos_d[c] = (pos_q[c] == 4'd0) ? POS_MAX : pos_q[c] - 4'd1;
        end else begin
          pos_d[c] = (pos_q[c] == POS_MAX) ? 4'd0 : pos_q[c] + 4'd1;
        end
      end else begin
        step_d[c] = 1'b0;
      end
    end
  end

  // State and output registers, all cleared to their idle values on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      cand_q     <= '0;
      stable_q   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= CNT_ZERO;
        pos_q[c] <= POS_RST;
      end
      hist_q     <= '0;
      hist_vld_q <= '0;
      pend_vld_q <= '0;
      pend_ccw_q <= '0;
      step_q     <= '0;
      dir_q      <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cand_q     <= cand_d;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      hist_q     <= hist_d;
      hist_vld_q <= hist_vld_d;
      pend_vld_q <= pend_vld_d;
      pend_ccw_q <= pend_ccw_d;
      pos_q      <= pos_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
    end
  end

  assign bus.pos     = pos_q;
  assign bus.step    = step_q;
  assign bus.dir_ccw = dir_q;

endmodule

// File: tb/tb_ls30rot_tracker.sv
// Self-checking bench for ls30rot_tracker: directed vector table, hand-written
// corner sequences and randomized stimulus, all compared against a
// position/phase-index reference model.
module tb_ls30rot_tracker;

  localparam int NCH  = 2;
  localparam int NPH  = 4;
  localparam int NPOS = 12;
  localparam int DEB  = 3;
  localparam int RPOS = 11;

  logic clk;
  logic rst_n;

  ls30rot_tracker_if #(.NUM_CH(NCH), .PHASES(NPH)) bus ();

  ls30rot_tracker #(
    .NUM_CH(NCH), .PHASES(NPH), .POSITIONS(NPOS), .DEBOUNCE(DEB), .RESET_POS(RPOS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int step_seen[NCH];

  // Reference model: codes as integers, history as phase index (-1 = none)
  int m_s1[NCH], m_s2[NCH], m_cand[NCH], m_cnt[NCH], m_stable[NCH];
  int m_hist[NCH], m_pend[NCH], m_pos[NCH], m_step[NCH], m_dir[NCH];

  typedef struct {
    logic [3:0] c0;
    logic [3:0] c1;
    int n;
    int p0, p1;
    int s0, s1;
    int d0, d1;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_s1[c] = 0; m_s2[c] = 0; m_cand[c] = 0; m_cnt[c] = 0; m_stable[c] = 0;
      m_hist[c] = -1; m_pend[c] = 0; m_pos[c] = RPOS; m_step[c] = 0; m_dir[c] = 0;
    end
  endfunction

  function automatic int phase_index(input int code);
    int k;
    k = -1;
    for (int i = 0; i < NPH; i++) if (code == (1 << i)) k = i;
    return k;
  endfunction

  function automatic void model_update();
    logic [NCH*NPH-1:0] raw;
    raw = ~bus.rot_n;
    for (int c = 0; c < NCH; c++) begin
      int delta, k, d, newcode;
      newcode = int'(raw[c*NPH +: NPH]);
      delta = 0;
      if (bus.sample_en) begin
        if (m_s2[c] == m_cand[c]) begin
          if (m_cnt[c] < DEB) m_cnt[c]++;
        end else begin
          m_cand[c] = m_s2[c];
          m_cnt[c]  = 1;
        end
        if (m_cnt[c] == DEB && m_cand[c] != m_stable[c]) begin
          m_stable[c] = m_cand[c];
          k = phase_index(m_cand[c]);
          if (k >= 0) begin
            if (m_hist[c] >= 0) begin
              d = (k - m_hist[c] + NPH) % NPH;
              if (d == 1) delta = 1;
              else if (d == NPH - 1) delta = -1;
            end
            m_hist[c] = k;
          end
        end
      end
      if (bus.recenter[c]) begin
        m_pos[c] = RPOS; m_step[c] = 0; m_hist[c] = -1; m_pend[c] = 0;
      end else begin
        if (m_pend[c] != 0 && !bus.wait_data) begin
          m_pos[c]  = (m_pos[c] + m_pend[c] + NPOS) % NPOS;
          m_step[c] = 1;
          m_dir[c]  = (m_pend[c] < 0) ? 1 : 0;
        end else begin
          m_step[c] = 0;
        end
        m_pend[c] = delta;
      end
      m_s2[c] = m_s1[c];
      m_s1[c] = newcode;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_update();
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("model_pos_ch%0d", c), int'(bus.pos[c*4 +: 4]), m_pos[c]);
      check($sformatf("model_step_ch%0d", c), int'(bus.step[c]), m_step[c]);
      check($sformatf("model_dir_ch%0d", c), int'(bus.dir_ccw[c]), m_dir[c]);
      if (bus.step[c]) step_seen[c]++;
    end
  endtask

  task automatic hold(input logic [3:0] c0, input logic [3:0] c1, input int n);
    bus.rot_n = ~{c1, c0};
    repeat (n) tick();
  endtask

  task automatic clear_seen();
    for (int c = 0; c < NCH; c++) step_seen[c] = 0;
  endtask

  function automatic vec_t mk(input logic [3:0] c0, input logic [3:0] c1, input int n,
                              input int p0, input int p1, input int s0, input int s1,
                              input int d0, input int d1);
    vec_t v;
    v.c0 = c0; v.c1 = c1; v.n = n; v.p0 = p0; v.p1 = p1;
    v.s0 = s0; v.s1 = s1; v.d0 = d0; v.d1 = d1;
    return v;
  endfunction

  initial begin
    logic [3:0] ccw_seq [4];
    int exp_p1;

    // Directed table: codes held with sample_en high every clk
    vecs.push_back(mk(4'b0000, 4'b0000, 20, 11, 11, 0, 0, 0, 0));
    vecs.push_back(mk(4'b0001, 4'b0000, 8, 11, 11, 0, 0, 0, 0));
    vecs.push_back(mk(4'b0011, 4'b0000, 8, 11, 11, 0, 0, 0, 0));
    vecs.push_back(mk(4'b0010, 4'b0000, 8, 0, 11, 1, 0, 0, 0));
    vecs.push_back(mk(4'b0110, 4'b0000, 8, 0, 11, 0, 0, 0, 0));
    vecs.push_back(mk(4'b0100, 4'b0000, 8, 1, 11, 1, 0, 0, 0));
    vecs.push_back(mk(4'b0100, 4'b1000, 8, 1, 11, 0, 0, 0, 0));
    vecs.push_back(mk(4'b0100, 4'b0001, 8, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(4'b0100, 4'b1000, 8, 1, 11, 0, 1, 0, 1));
    ccw_seq[0] = 4'b0100; ccw_seq[1] = 4'b0010; ccw_seq[2] = 4'b0001; ccw_seq[3] = 4'b1000;
    exp_p1 = 11;
    for (int i = 0; i < 12; i++) begin
      exp_p1 = (exp_p1 == 0) ? 11 : exp_p1 - 1;
      vecs.push_back(mk(4'b0100, ccw_seq[i % 4], 8, 1, exp_p1, 0, 1, 0, 1));
    end
    vecs.push_back(mk(4'b1000, 4'b1000, 8, 2, 11, 1, 0, 0, 1));
    vecs.push_back(mk(4'b0001, 4'b1000, 8, 3, 11, 1, 0, 0, 1));
    vecs.push_back(mk(4'b0010, 4'b1000, 2, 3, 11, 0, 0, 0, 1));
    vecs.push_back(mk(4'b0001, 4'b1000, 8, 3, 11, 0, 0, 0, 1));

    // Reset
    rst_n = 1'b0;
    bus.sample_en = 1'b1;
    bus.wait_data = 1'b0;
    bus.recenter  = '0;
    bus.rot_n     = '1;
    model_reset();
    clear_seen();
    repeat (2) @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      check("reset_pos", int'(bus.pos[c*4 +: 4]), RPOS);
      check("reset_step", int'(bus.step[c]), 0);
      check("reset_dir", int'(bus.dir_ccw[c]), 0);
    end
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      clear_seen();
      hold(vecs[i].c0, vecs[i].c1, vecs[i].n);
      check($sformatf("vec%0d_pos0", i), int'(bus.pos[3:0]), vecs[i].p0);
      check($sformatf("vec%0d_pos1", i), int'(bus.pos[7:4]), vecs[i].p1);
      check($sformatf("vec%0d_steps0", i), step_seen[0], vecs[i].s0);
      check($sformatf("vec%0d_steps1", i), step_seen[1], vecs[i].s1);
      check($sformatf("vec%0d_dir0", i), int'(bus.dir_ccw[0]), vecs[i].d0);
      check($sformatf("vec%0d_dir1", i), int'(bus.dir_ccw[1]), vecs[i].d1);
    end

    // sample_en low for 50 clk with toggling input: nothing moves
    clear_seen();
    bus.sample_en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      bus.rot_n = 8'($urandom);
      tick();
    end
    hold(4'b0001, 4'b1000, 4);
    check("gate_pos0", int'(bus.pos[3:0]), 3);
    check("gate_pos1", int'(bus.pos[7:4]), 11);
    check("gate_steps", step_seen[0] + step_seen[1], 0);
    bus.sample_en = 1'b1;
    hold(4'b0001, 4'b1000, 8);
    check("regate_pos0", int'(bus.pos[3:0]), 3);
    check("regate_steps", step_seen[0] + step_seen[1], 0);

    // wait_data freezes a valid CW step; history still advances
    clear_seen();
    bus.wait_data = 1'b1;
    hold(4'b0010, 4'b1000, 8);
    check("wait_pos0", int'(bus.pos[3:0]), 3);
    check("wait_steps0", step_seen[0], 0);
    bus.wait_data = 1'b0;
    hold(4'b0100, 4'b1000, 8);
    check("after_wait_pos0", int'(bus.pos[3:0]), 4);
    check("after_wait_steps0", step_seen[0], 1);

    // recenter ch0 on the cycle its step would apply, ch1 steps normally
    clear_seen();
    bus.rot_n = ~{4'b0001, 4'b1000};
    repeat (5) tick();
    bus.recenter = 2'b01;
    tick();
    bus.recenter = 2'b00;
    repeat (2) tick();
    check("recenter_pos0", int'(bus.pos[3:0]), RPOS);
    check("recenter_steps0", step_seen[0], 0);
    check("recenter_pos1", int'(bus.pos[7:4]), 0);
    check("recenter_steps1", step_seen[1], 1);
    // history invalidated: adjacent 1000->0001 must not step
    clear_seen();
    hold(4'b0001, 4'b0001, 8);
    check("post_recenter_pos0", int'(bus.pos[3:0]), RPOS);
    check("post_recenter_steps0", step_seen[0], 0);
    hold(4'b0001, 4'b1000, 8);
    check("ccw_pos1", int'(bus.pos[7:4]), 11);
    check("ccw_dir1", int'(bus.dir_ccw[1]), 1);

    // async reset mid-debounce
    bus.rot_n = ~{4'b0100, 4'b0010};
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < NCH; c++) begin
      check("async_rst_pos", int'(bus.pos[c*4 +: 4]), RPOS);
      check("async_rst_step", int'(bus.step[c]), 0);
      check("async_rst_dir", int'(bus.dir_ccw[c]), 0);
    end
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    hold(4'b0100, 4'b0010, 8);

    // Randomized stimulus against the reference model
    for (int i = 0; i < 300; i++) begin
      logic [3:0] cd [NCH];
      int len;
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 9) < 8) cd[c] = 4'(1 << $urandom_range(0, 3));
        else cd[c] = 4'($urandom);
      end
      bus.rot_n = ~{cd[1], cd[0]};
      len = $urandom_range(1, 10);
      for (int j = 0; j < len; j++) begin
        bus.sample_en = ($urandom_range(0, 3) != 0);
        bus.wait_data = ($urandom_range(0, 9) == 0);
        bus.recenter  = {($urandom_range(0, 32) == 0), ($urandom_range(0, 32) == 0)};
        tick();
      end
    end
    bus.recenter = '0;
    bus.wait_data = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
